// File: rtl/shift_reg_universal_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_reg_universal_if
// Purpose  : Bundles the control, serial and parallel signals of the universal
//            shift register into one interface.
// Signals  : en, mode[1:0], sdi_left, sdi_right, rotate, pdi[WIDTH-1:0] (to reg)
//            pdo[WIDTH-1:0], sdo_left, sdo_right, shift_cnt[CNT_W-1:0],
//            frame_done (from reg)
// Modports : master - drives controls/data, observes results
//            slave  - the shift register itself
// Revision : 1.0 - initial release
// ============================================================================
interface shift_reg_universal_if #(
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(WIDTH);

  logic             en;
  logic [1:0]       mode;
  logic             sdi_left;
  logic             sdi_right;
  logic             rotate;
  logic [WIDTH-1:0] pdi;
  logic [WIDTH-1:0] pdo;
  logic             sdo_left;
  logic             sdo_right;
  logic [CNT_W-1:0] shift_cnt;
  logic             frame_done;

  modport master (
    output en, mode, sdi_left, sdi_right, rotate, pdi,
    input  pdo, sdo_left, sdo_right, shift_cnt, frame_done
  );

  modport slave (
    input  en, mode, sdi_left, sdi_right, rotate, pdi,
    output pdo, sdo_left, sdo_right, shift_cnt, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/shift_reg_universal.sv
`default_nettype none
// ============================================================================
// Module   : shift_reg_universal
// Purpose  : WIDTH-bit universal shift register: hold, shift right, shift
//            left, parallel load, with a frame counter that pulses frame_done
//            after every WIDTH shifts (either direction counts).
// Ports    : clk   - rising-edge clock
//            reset - asynchronous active-high reset
//            bus   - shift_reg_universal_if.slave (controls, serial/parallel
//                    data in, pdo/sdo_*/shift_cnt/frame_done out)
// Options  : SHIFT_REG_ROTATE_EN - when defined, rotate=1 recirculates the
//            outgoing bit instead of taking sdi_left/sdi_right.
// Revision : 1.0 - initial release
// ============================================================================
module shift_reg_universal #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             reset,
  shift_reg_universal_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0]       c_mode_shr  = 2'b01;
  localparam logic [1:0]       c_mode_shl  = 2'b10;
  localparam logic [1:0]       c_mode_load = 2'b11;
  localparam logic [CNT_W-1:0] c_cnt_last  = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fd_q, fd_d;
  logic             w_in_msb;   // bit entering at the MSB on a right shift
  logic             w_in_lsb;   // bit entering at the LSB on a left shift

`ifdef SHIFT_REG_ROTATE_EN
  assign w_in_msb = bus.rotate ? sr_q[0]       : bus.sdi_left;
  assign w_in_lsb = bus.rotate ? sr_q[WIDTH-1] : bus.sdi_right;
`else
  // rotate stays on the interface but has no effect in this build.
  logic w_unused_rotate;
  assign w_unused_rotate = bus.rotate;
  assign w_in_msb        = bus.sdi_left;
  assign w_in_lsb        = bus.sdi_right;
`endif

  always_comb begin
    logic w_shift;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    fd_d    = 1'b0;
    w_shift = 1'b0;
    if (bus.en) begin
      case (bus.mode)
        c_mode_shr: begin
          sr_d    = {w_in_msb, sr_q[WIDTH-1:1]};
          w_shift = 1'b1;
        end
        c_mode_shl: begin
          sr_d    = {sr_q[WIDTH-2:0], w_in_lsb};
          w_shift = 1'b1;
        end
        c_mode_load: begin
          // A load abandons any partially shifted frame.
          sr_d  = bus.pdi;
          cnt_d = '0;
        end
        default: ;
      endcase
      if (w_shift) begin
        if (cnt_q == c_cnt_last) begin
          cnt_d = '0;
          fd_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
      fd_q  <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      fd_q  <= fd_d;
    end
  end

  assign bus.pdo        = sr_q;
  assign bus.sdo_left   = sr_q[WIDTH-1];
  assign bus.sdo_right  = sr_q[0];
  assign bus.shift_cnt  = cnt_q;
  assign bus.frame_done = fd_q;
endmodule
`default_nettype wire

// File: tb/tb_shift_reg_universal.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_reg_universal
// Purpose  : Self-checking bench for shift_reg_universal (WIDTH=8) using a
//            behavioural model of the register word and frame position.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_reg_universal;
  localparam int W = 8;
`ifdef SHIFT_REG_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;

  // Behavioural model: word value, shifts so far in the frame, pulse.
  logic [W-1:0] m_sr = '0;
  int           m_cnt = 0;
  logic         m_fd = 1'b0;

  shift_reg_universal_if #(.WIDTH(W)) bus ();

  shift_reg_universal #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model, land 1 time unit after the edge.
  task automatic do_cycle(input bit e, input logic [1:0] md, input bit sl,
                          input bit sr_in, input bit rt, input logic [W-1:0] p);
    bit b;
    bit shifted;
    bus.en = e; bus.mode = md; bus.sdi_left = sl; bus.sdi_right = sr_in;
    bus.rotate = rt; bus.pdi = p;
    m_fd = 1'b0;
    shifted = 1'b0;
    if (e) begin
      if (md == 2'd1) begin
        b = (ROT && rt) ? m_sr[0] : sl;
        m_sr = (m_sr >> 1) + (b ? 8'h80 : 8'h00);
        shifted = 1'b1;
      end else if (md == 2'd2) begin
        b = (ROT && rt) ? m_sr[W-1] : sr_in;
        m_sr = (m_sr << 1) + (b ? 8'h01 : 8'h00);
        shifted = 1'b1;
      end else if (md == 2'd3) begin
        m_sr = p;
        m_cnt = 0;
      end
    end
    if (shifted) begin
      m_cnt = m_cnt + 1;
      if (m_cnt == W) begin
        m_cnt = 0;
        m_fd = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.en = 0; bus.mode = 0; bus.sdi_left = 0; bus.sdi_right = 0;
    bus.rotate = 0; bus.pdi = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    n_checks++;
    if (bus.pdo !== 8'h00) $display("FAIL reset_pdo: got %h want 00", bus.pdo); else n_pass++;
    n_checks++;
    if (bus.shift_cnt !== 3'd0 || bus.frame_done !== 1'b0)
      $display("FAIL reset_cnt_fd: got cnt=%0d fd=%b want 0/0", bus.shift_cnt, bus.frame_done);
    else n_pass++;
    n_checks++;
    if (bus.sdo_left !== 1'b0 || bus.sdo_right !== 1'b0)
      $display("FAIL reset_sdo: got %b%b want 00", bus.sdo_left, bus.sdo_right);
    else n_pass++;
    reset = 1'b0;
    m_sr = '0; m_cnt = 0; m_fd = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset;
    logic [4:0] pat;
    pat = 5'b11100;
    do_cycle(1, 2'd3, 0, 0, 0, 8'h01);
    for (int i = 0; i < 5; i++) do_cycle(1, 2'd2, 0, pat[4-i], 0, '0);
    n_checks++;
    if (bus.pdo !== 8'h3C || bus.shift_cnt !== 3'd5)
      $display("FAIL midframe_setup: got pdo=%h cnt=%0d want 3c/5", bus.pdo, bus.shift_cnt);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (bus.pdo !== 8'h00 || bus.shift_cnt !== 3'd0 || bus.frame_done !== 1'b0 ||
        bus.sdo_left !== 1'b0 || bus.sdo_right !== 1'b0)
      $display("FAIL async_reset: got pdo=%h cnt=%0d fd=%b want 00/0/0",
               bus.pdo, bus.shift_cnt, bus.frame_done);
    else n_pass++;
    #1 reset = 1'b0;
    m_sr = '0; m_cnt = 0; m_fd = 0;
    for (int i = 0; i < W; i++) begin
      do_cycle(1, 2'd1, 1'($urandom), 0, 0, '0);
      n_checks++;
      if (bus.frame_done !== (i == W - 1) || bus.pdo !== m_sr)
        $display("FAIL post_reset_frame[%0d]: got fd=%b pdo=%h want fd=%b pdo=%h",
                 i, bus.frame_done, bus.pdo, (i == W - 1), m_sr);
      else n_pass++;
    end
  endtask

  task automatic test_shift_right;
    logic [7:0] seq;
    seq = 8'b01001010;
    do_cycle(1, 2'd3, 0, 0, 0, 8'hA5);
    for (int i = 0; i < W; i++) begin
      do_cycle(1, 2'd1, 0, 1'($urandom), 0, '0);
      n_checks++;
      if (bus.sdo_right !== seq[7-i] || bus.frame_done !== (i == W - 1) ||
          bus.shift_cnt !== m_cnt[2:0])
        $display("FAIL shr[%0d]: got sdo_r=%b fd=%b cnt=%0d want %b/%b/%0d", i,
                 bus.sdo_right, bus.frame_done, bus.shift_cnt, seq[7-i], (i == W - 1), m_cnt);
      else n_pass++;
    end
    n_checks++;
    if (bus.pdo !== 8'h00 || bus.shift_cnt !== 3'd0)
      $display("FAIL shr_end: got pdo=%h cnt=%0d want 00/0", bus.pdo, bus.shift_cnt);
    else n_pass++;
  endtask

  task automatic test_shift_left;
    logic [W-1:0] exp;
    do_cycle(1, 2'd3, 0, 0, 0, 8'h00);
    for (int i = 0; i < W; i++) begin
      do_cycle(1, 2'd2, 1'($urandom), 1, 0, '0);
      exp = W'((1 << (i + 1)) - 1);
      n_checks++;
      if (bus.pdo !== exp || bus.sdo_left !== (i == W - 1) || bus.frame_done !== (i == W - 1))
        $display("FAIL shl[%0d]: got pdo=%h sdo_l=%b fd=%b want %h/%b/%b", i,
                 bus.pdo, bus.sdo_left, bus.frame_done, exp, (i == W - 1), (i == W - 1));
      else n_pass++;
    end
  endtask

  task automatic test_enable_hold;
    logic [W-1:0] held;
    do_cycle(1, 2'd3, 0, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) do_cycle(1, 2'd1, 1, 0, 0, '0);
    held = m_sr;
    for (int i = 0; i < 4; i++) begin
      do_cycle(0, 2'($urandom), 1, 1, 0, 8'hFF);
      n_checks++;
      if (bus.shift_cnt !== 3'd3 || bus.pdo !== held || bus.frame_done !== 1'b0)
        $display("FAIL en_hold[%0d]: got cnt=%0d pdo=%h fd=%b want 3/%h/0", i,
                 bus.shift_cnt, bus.pdo, bus.frame_done, held);
      else n_pass++;
    end
    for (int i = 0; i < 2; i++) do_cycle(1, 2'd2, 0, 1, 0, '0);
    n_checks++;
    if (bus.shift_cnt !== 3'd5) $display("FAIL en_resume: got cnt=%0d want 5", bus.shift_cnt);
    else n_pass++;
    do_cycle(1, 2'd3, 0, 0, 0, 8'h5A);
    n_checks++;
    if (bus.shift_cnt !== 3'd0 || bus.pdo !== 8'h5A)
      $display("FAIL load_clear: got cnt=%0d pdo=%h want 0/5a", bus.shift_cnt, bus.pdo);
    else n_pass++;
    for (int i = 0; i < W; i++) begin
      do_cycle(1, 2'd1, 1'($urandom), 0, 0, '0);
      n_checks++;
      if (bus.frame_done !== (i == W - 1) || bus.pdo !== m_sr)
        $display("FAIL post_load[%0d]: got fd=%b pdo=%h want %b/%h", i,
                 bus.frame_done, bus.pdo, (i == W - 1), m_sr);
      else n_pass++;
    end
  endtask

  task automatic test_rotate;
    do_cycle(1, 2'd3, 0, 0, 0, 8'h81);
    do_cycle(1, 2'd2, 0, 0, 1, '0);
    n_checks++;
    if (bus.pdo !== (ROT ? 8'h03 : 8'h02))
      $display("FAIL rotate_1: got %h want %h", bus.pdo, (ROT ? 8'h03 : 8'h02));
    else n_pass++;
    for (int i = 1; i < W; i++) do_cycle(1, 2'd2, 0, 0, 1, '0);
    n_checks++;
    if (bus.pdo !== (ROT ? 8'h81 : 8'h00) || bus.frame_done !== 1'b1)
      $display("FAIL rotate_8: got pdo=%h fd=%b want %h/1", bus.pdo, bus.frame_done,
               (ROT ? 8'h81 : 8'h00));
    else n_pass++;
  endtask

  task automatic test_alternate;
    do_cycle(1, 2'd3, 0, 0, 0, 8'($urandom));
    for (int i = 0; i < W; i++) begin
      do_cycle(1, (i % 2 == 0) ? 2'd1 : 2'd2, 1'($urandom), 1'($urandom), 0, '0);
      n_checks++;
      if (bus.frame_done !== (i == W - 1) || bus.pdo !== m_sr)
        $display("FAIL alternate[%0d]: got fd=%b pdo=%h want %b/%h", i,
                 bus.frame_done, bus.pdo, (i == W - 1), m_sr);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    do_cycle(1, 2'd3, 0, 0, 0, 8'h00);
    for (int i = 0; i < 3 * W; i++) begin
      do_cycle(1, 2'($urandom_range(1, 2)), 1'($urandom), 1'($urandom), 0, '0);
      n_checks++;
      if (bus.frame_done !== (i % W == W - 1) || bus.shift_cnt !== m_cnt[2:0])
        $display("FAIL b2b[%0d]: got fd=%b cnt=%0d want %b/%0d", i,
                 bus.frame_done, bus.shift_cnt, (i % W == W - 1), m_cnt);
      else n_pass++;
    end
    // Frame has just completed; load immediately.
    do_cycle(1, 2'd3, 0, 0, 0, 8'hC3);
    n_checks++;
    if (bus.frame_done !== 1'b0 || bus.pdo !== 8'hC3 || bus.shift_cnt !== 3'd0)
      $display("FAIL load_after_frame: got fd=%b pdo=%h cnt=%0d want 0/c3/0",
               bus.frame_done, bus.pdo, bus.shift_cnt);
    else n_pass++;
  endtask

  task automatic test_random;
    for (int i = 0; i < 300; i++) begin
      do_cycle(($urandom_range(0, 7) != 0), 2'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), 8'($urandom));
      n_checks++;
      if (bus.pdo !== m_sr || bus.sdo_left !== m_sr[W-1] || bus.sdo_right !== m_sr[0] ||
          bus.shift_cnt !== m_cnt[2:0] || bus.frame_done !== m_fd)
        $display("FAIL random[%0d]: got pdo=%h cnt=%0d fd=%b sdo=%b%b want %h/%0d/%b", i,
                 bus.pdo, bus.shift_cnt, bus.frame_done, bus.sdo_left, bus.sdo_right,
                 m_sr, m_cnt, m_fd);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_shift_right();
    test_shift_left();
    test_enable_hold();
    test_rotate();
    test_alternate();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
